// File: rtl/spi_reg_pkg.sv
// Shared encodings and frame constants for the SPI-to-register-bank bridge.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FRAME_BITS        = 16;
  localparam int RW_BIT            = 15;
  localparam int DEF_STROBE_CYCLES = 3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit multi-flop synchronizer with selectable reset value.
// Latency STAGES cycles; no backpressure.
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// Mode-0 SPI slave turning 16-bit frames into register-bank read/write strobes.
// Pin-to-edge latency SYNC_STAGES+1 cycles; no backpressure, strobes are fixed-length.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_n,
  input  logic                  spi_csn_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  abort_o
);

  localparam int HDR_BITS = FRAME_BITS - DATA_WIDTH;
  localparam int CNT_W    = $clog2(FRAME_BITS);
  localparam int SC_W     = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  logic csn_s, sck_s, mosi_s;

  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk_i (clk_i), .rstn_n(rstn_n), .d_i(spi_csn_i), .q_o(csn_s)
  );
  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i (clk_i), .rstn_n(rstn_n), .d_i(spi_sck_i), .q_o(sck_s)
  );
  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (clk_i), .rstn_n(rstn_n), .d_i(spi_mosi_i), .q_o(mosi_s)
  );

  state_e                  state_q;
  logic                    csn_q, sck_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-2:0]   rx_q;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    load_q;
  logic                    rw_q;
  logic [SC_W-1:0]         strb_cnt_q;
  logic                    read_en_q, write_en_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    miso_q, oe_q, abort_q;

  logic                    csn_fall, csn_rise, sck_rise, sck_fall;
  logic                    strb_last, rd_last;
  logic [DATA_WIDTH-1:0]   rx_d;

  assign csn_fall  = csn_q & ~csn_s;
  assign csn_rise  = ~csn_q & csn_s;
  assign sck_rise  = ~sck_q & sck_s;
  assign sck_fall  = sck_q & ~sck_s;
  assign strb_last = (read_en_q | write_en_q) && (strb_cnt_q == '0);
  assign rd_last   = read_en_q && (strb_cnt_q == '0);
  assign rx_d      = {rx_q, mosi_s};

  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) begin
      state_q    <= ST_IDLE;
      csn_q      <= 1'b1;
      sck_q      <= 1'b0;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rdata_q    <= '0;
      load_q     <= 1'b0;
      rw_q       <= 1'b0;
      strb_cnt_q <= '0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      csn_q   <= csn_s;
      sck_q   <= sck_s;
      oe_q    <= ~csn_s;
      abort_q <= 1'b0;

      // Shared strobe timer; runs to completion regardless of frame state.
      if (strb_last) begin
        read_en_q  <= 1'b0;
        write_en_q <= 1'b0;
      end else if (read_en_q | write_en_q) begin
        strb_cnt_q <= strb_cnt_q - SC_W'(1);
      end
      if (rd_last) begin
        rdata_q <= read_data_i;
      end
      load_q <= rd_last;

      case (state_q)
        ST_IDLE: begin
          if (csn_fall) begin
            state_q   <= ST_HDR;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
          end
        end

        ST_HDR: begin
          if (csn_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (sck_rise) begin
            rx_q      <= rx_d[DATA_WIDTH-2:0];
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(HDR_BITS - 1)) begin
              addr_q  <= rx_d[ADDR_WIDTH-1:0];
              rw_q    <= rx_d[RW_BIT - DATA_WIDTH];
              state_q <= ST_DATA;
              if (!rx_d[RW_BIT - DATA_WIDTH]) begin
                read_en_q  <= 1'b1;
                strb_cnt_q <= SC_W'(STROBE_CYCLES - 1);
              end
            end
          end
        end

        ST_DATA: begin
          if (csn_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            // Read data lands in TX well before the first data-phase falling edge.
            if (load_q && !rw_q) begin
              tx_q <= rdata_q;
            end else if (sck_fall && !rw_q) begin
              miso_q <= tx_q[DATA_WIDTH-1];
              tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (sck_rise) begin
              rx_q      <= rx_d[DATA_WIDTH-2:0];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                state_q <= ST_DONE;
                if (rw_q) begin
                  wdata_q    <= rx_d;
                  write_en_q <= 1'b1;
                  strb_cnt_q <= SC_W'(STROBE_CYCLES - 1);
                end
              end
            end
          end
        end

        ST_DONE: begin
          if (csn_rise) begin
            miso_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign addr_o        = addr_q;
  assign write_data_o  = wdata_q;
  assign write_en_o    = write_en_q;
  assign read_en_o     = read_en_q;
  assign abort_o       = abort_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI host model at clk/16 plus a strobe monitor.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  logic       clk_i = 1'b0;
  logic       rstn_n = 1'b0;
  logic       spi_csn_i = 1'b1;
  logic       spi_sck_i = 1'b0;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o, spi_miso_oe_o;
  logic [6:0] addr_o;
  logic [7:0] write_data_o;
  logic       write_en_o, read_en_o, abort_o;
  logic [7:0] read_data_i = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  spi_reg_bridge dut (
    .clk_i        (clk_i),
    .rstn_n       (rstn_n),
    .spi_csn_i    (spi_csn_i),
    .spi_sck_i    (spi_sck_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .addr_o       (addr_o),
    .write_data_o (write_data_o),
    .write_en_o   (write_en_o),
    .read_en_o    (read_en_o),
    .read_data_i  (read_data_i),
    .abort_o      (abort_o)
  );

  always #5 clk_i = ~clk_i;

  // Strobe/abort monitor sampled on the falling clock edge.
  int         wr_cyc = 0, rd_cyc = 0, ab_cyc = 0, ev_n = 0;
  logic       wr_prev = 1'b0, rd_prev = 1'b0;
  logic [1:0] ev_kind [0:31];
  logic [6:0] ev_addr [0:31];
  logic [7:0] ev_data [0:31];

  always @(negedge clk_i) begin
    if (write_en_o) wr_cyc++;
    if (read_en_o)  rd_cyc++;
    if (abort_o)    ab_cyc++;
    if (ev_n < 32 && ((write_en_o && !wr_prev) || (read_en_o && !rd_prev))) begin
      ev_kind[ev_n] = write_en_o ? 2'd2 : 2'd1;
      ev_addr[ev_n] = addr_o;
      ev_data[ev_n] = write_data_o;
      ev_n++;
    end
    wr_prev = write_en_o;
    rd_prev = read_en_o;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Host transfer: nbits SCK pulses, MISO captured at SCK rise for bits 8..15.
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input bit end_csn,
                          output logic [7:0] rx, output logic hdr_or);
    rx = 8'h00;
    hdr_or = 1'b0;
    spi_csn_i = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = (i < 16) ? frame[15 - i] : 1'b0;
      wait_clk(8);
      spi_sck_i = 1'b1;
      if (i < 8) hdr_or = hdr_or | spi_miso_o;
      else if (i < 16) rx = {rx[6:0], spi_miso_o};
      wait_clk(8);
      spi_sck_i = 1'b0;
    end
    wait_clk(8);
    if (end_csn) begin
      spi_csn_i = 1'b1;
      wait_clk(12);
    end
  endtask

  task automatic test_reset();
    rstn_n = 1'b0;
    wait_clk(4);
    n_vec++;
    if ({addr_o, write_data_o, write_en_o, read_en_o, abort_o, spi_miso_o, spi_miso_oe_o} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {addr_o, write_data_o, write_en_o, read_en_o, abort_o, spi_miso_o, spi_miso_oe_o});
    end
    rstn_n = 1'b1;
    wait_clk(6);
    n_vec++;
    if (dut.state_q !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d, expected IDLE", dut.state_q);
    end
    n_vec++;
    if (spi_miso_oe_o !== 1'b0) begin
      n_err++; $display("FAIL reset_oe: got %b, expected 0", spi_miso_oe_o);
    end
  endtask

  task automatic test_write();
    logic [7:0] rx; logic hor;
    int w0 = wr_cyc, a0 = ab_cyc, e0 = ev_n;
    spi_xfer(16'h853C, 16, 1'b1, rx, hor);
    n_vec++;
    if (ev_n - e0 !== 1) begin n_err++; $display("FAIL write_count: got %0d strobes, expected 1", ev_n - e0); end
    n_vec++;
    if (ev_kind[e0] !== 2'd2 || ev_addr[e0] !== 7'h05 || ev_data[e0] !== 8'h3C) begin
      n_err++; $display("FAIL write_access: kind %0d addr %h data %h, expected 2/05/3c", ev_kind[e0], ev_addr[e0], ev_data[e0]);
    end
    n_vec++;
    if (wr_cyc - w0 !== 3) begin n_err++; $display("FAIL write_len: got %0d cycles, expected 3", wr_cyc - w0); end
    n_vec++;
    if (ab_cyc - a0 !== 0) begin n_err++; $display("FAIL write_abort: got %0d, expected 0", ab_cyc - a0); end
    n_vec++;
    if (addr_o !== 7'h05 || write_data_o !== 8'h3C) begin
      n_err++; $display("FAIL write_hold: addr %h data %h, expected 05/3c", addr_o, write_data_o);
    end
  endtask

  task automatic test_read();
    logic [7:0] rx; logic hor;
    int r0 = rd_cyc, w0 = wr_cyc, e0 = ev_n;
    read_data_i = 8'hA5;
    spi_xfer(16'h0A00, 16, 1'b0, rx, hor);
    n_vec++;
    if (spi_miso_oe_o !== 1'b1) begin n_err++; $display("FAIL read_oe_active: got %b, expected 1", spi_miso_oe_o); end
    spi_csn_i = 1'b1;
    wait_clk(12);
    n_vec++;
    if (spi_miso_oe_o !== 1'b0) begin n_err++; $display("FAIL read_oe_idle: got %b, expected 0", spi_miso_oe_o); end
    n_vec++;
    if (rx !== 8'hA5) begin n_err++; $display("FAIL read_miso: got %h, expected a5", rx); end
    n_vec++;
    if (hor !== 1'b0) begin n_err++; $display("FAIL read_hdr_miso: got %b, expected 0", hor); end
    n_vec++;
    if (ev_n - e0 !== 1 || ev_kind[e0] !== 2'd1 || ev_addr[e0] !== 7'h0A) begin
      n_err++; $display("FAIL read_access: n %0d kind %0d addr %h, expected 1/1/0a", ev_n - e0, ev_kind[e0], ev_addr[e0]);
    end
    n_vec++;
    if (rd_cyc - r0 !== 3) begin n_err++; $display("FAIL read_len: got %0d cycles, expected 3", rd_cyc - r0); end
    n_vec++;
    if (wr_cyc - w0 !== 0) begin n_err++; $display("FAIL read_no_write: got %0d, expected 0", wr_cyc - w0); end
  endtask

  task automatic test_abort();
    logic [7:0] rx; logic hor;
    int w0 = wr_cyc, a0 = ab_cyc, r0 = rd_cyc;
    spi_xfer(16'h9FFF, 12, 1'b1, rx, hor);
    n_vec++;
    if (ab_cyc - a0 !== 1) begin n_err++; $display("FAIL abort_pulse: got %0d cycles, expected 1", ab_cyc - a0); end
    n_vec++;
    if (wr_cyc - w0 !== 0 || rd_cyc - r0 !== 0) begin
      n_err++; $display("FAIL abort_no_access: wr %0d rd %0d, expected 0/0", wr_cyc - w0, rd_cyc - r0);
    end
    n_vec++;
    if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL abort_state: got %0d, expected IDLE", dut.state_q); end
  endtask

  task automatic test_extra_sck();
    logic [7:0] rx; logic hor;
    int w0 = wr_cyc, a0 = ab_cyc, e0 = ev_n;
    spi_xfer(16'h8111, 20, 1'b1, rx, hor);
    n_vec++;
    if (ev_n - e0 !== 1) begin n_err++; $display("FAIL extra_count: got %0d strobes, expected 1", ev_n - e0); end
    n_vec++;
    if (ev_kind[e0] !== 2'd2 || ev_addr[e0] !== 7'h01 || ev_data[e0] !== 8'h11) begin
      n_err++; $display("FAIL extra_access: kind %0d addr %h data %h, expected 2/01/11", ev_kind[e0], ev_addr[e0], ev_data[e0]);
    end
    n_vec++;
    if (wr_cyc - w0 !== 3 || ab_cyc - a0 !== 0) begin
      n_err++; $display("FAIL extra_len: wr %0d abort %0d, expected 3/0", wr_cyc - w0, ab_cyc - a0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx; logic hor;
    int e0, w0, waited;
    spi_xfer(16'h8655, 12, 1'b0, rx, hor);
    n_vec++;
    if (addr_o !== 7'h06 || spi_miso_oe_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_pre: addr %h oe %b, expected 06/1", addr_o, spi_miso_oe_o);
    end
    rstn_n = 1'b0;
    #1;
    n_vec++;
    if ({addr_o, write_data_o, write_en_o, read_en_o, abort_o, spi_miso_o, spi_miso_oe_o} !== 20'h0) begin
      n_err++; $display("FAIL midrst_outputs: got %h, expected 0",
               {addr_o, write_data_o, write_en_o, read_en_o, abort_o, spi_miso_o, spi_miso_oe_o});
    end
    spi_csn_i = 1'b1;
    wait_clk(6);
    rstn_n = 1'b1;
    wait_clk(6);
    // Reset while a read strobe is active.
    spi_xfer(16'h0300, 7, 1'b0, rx, hor);
    spi_mosi_i = 1'b0;
    wait_clk(8);
    spi_sck_i = 1'b1;
    waited = 0;
    while (!read_en_o && waited < 40) begin wait_clk(1); waited++; end
    n_vec++;
    if (read_en_o !== 1'b1) begin n_err++; $display("FAIL midrst_strobe_seen: got %b, expected 1", read_en_o); end
    rstn_n = 1'b0;
    #1;
    n_vec++;
    if (read_en_o !== 1'b0 || addr_o !== 7'h00) begin
      n_err++; $display("FAIL midrst_strobe_drop: ren %b addr %h, expected 0/00", read_en_o, addr_o);
    end
    spi_sck_i = 1'b0;
    spi_csn_i = 1'b1;
    wait_clk(6);
    rstn_n = 1'b1;
    wait_clk(6);
    e0 = ev_n; w0 = wr_cyc;
    spi_xfer(16'h8242, 16, 1'b1, rx, hor);
    n_vec++;
    if (ev_n - e0 !== 1 || ev_kind[e0] !== 2'd2 || ev_addr[e0] !== 7'h02 || ev_data[e0] !== 8'h42) begin
      n_err++; $display("FAIL midrst_next_write: n %0d kind %0d addr %h data %h, expected 1/2/02/42",
               ev_n - e0, ev_kind[e0], ev_addr[e0], ev_data[e0]);
    end
    n_vec++;
    if (wr_cyc - w0 !== 3) begin n_err++; $display("FAIL midrst_next_len: got %0d, expected 3", wr_cyc - w0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx; logic hor;
    int e0 = ev_n;
    read_data_i = 8'h5A;
    spi_xfer(16'h7F00, 16, 1'b1, rx, hor);
    read_data_i = 8'h00;
    spi_xfer(16'hFFAA, 16, 1'b1, rx, hor);
    n_vec++;
    if (ev_n - e0 !== 2) begin n_err++; $display("FAIL b2b_count: got %0d strobes, expected 2", ev_n - e0); end
    n_vec++;
    if (ev_kind[e0] !== 2'd1 || ev_addr[e0] !== 7'h7F) begin
      n_err++; $display("FAIL b2b_first_read: kind %0d addr %h, expected 1/7f", ev_kind[e0], ev_addr[e0]);
    end
    n_vec++;
    if (ev_kind[e0 + 1] !== 2'd2 || ev_addr[e0 + 1] !== 7'h7F || ev_data[e0 + 1] !== 8'hAA) begin
      n_err++; $display("FAIL b2b_second_write: kind %0d addr %h data %h, expected 2/7f/aa",
               ev_kind[e0 + 1], ev_addr[e0 + 1], ev_data[e0 + 1]);
    end
  endtask

  task automatic test_b2b_miso();
    logic [7:0] rx; logic hor;
    read_data_i = 8'h5A;
    spi_xfer(16'h7F00, 16, 1'b1, rx, hor);
    n_vec++;
    if (rx !== 8'h5A) begin n_err++; $display("FAIL b2b_miso: got %h, expected 5a", rx); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_extra_sck();
    test_reset_mid_frame();
    test_back_to_back();
    test_b2b_miso();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

SPI slave that turns serial frames from an external host into parallel accesses on the configuration/status register bank. Sits directly upstream of the register bank and drives its address, write-data, write-enable and read-enable inputs. Consumes the bank's read-data output and shifts it back on MISO. SPI pins are oversampled in the `clk_i` domain; there is no second clock.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: register address width; `1+ADDR_WIDTH` must equal 8.
- `DATA_WIDTH`, 8: register data width.
- `STROBE_CYCLES`, 3: cycles each `write_en_o`/`read_en_o` strobe is held, with address and data stable.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_csn_i`, `spi_sck_i`, `spi_mosi_i`.

Ports:
- `clk_i` in 1: system clock.
- `rstn_n` in 1: reset, asynchronous, active-low.
- `spi_csn_i` in 1: chip select, active-low, asynchronous to `clk_i`.
- `spi_sck_i` in 1: SPI clock, mode 0, at most `clk_i`/16.
- `spi_mosi_i` in 1: serial data in, MSB first.
- `spi_miso_o` out 1: serial data out, MSB first.
- `spi_miso_oe_o` out 1: MISO output enable.
- `addr_o` out `ADDR_WIDTH`: register address.
- `write_data_o` out `DATA_WIDTH`: register write data.
- `write_en_o` out 1: write strobe.
- `read_en_o` out 1: read strobe.
- `read_data_i` in `DATA_WIDTH`: register read data.
- `abort_o` out 1: one-cycle pulse when a frame is truncated.

## Operation
**Frame format** (16 bits, MSB first):
- Bit 15 is R/W (1 = write).
- Bits 14:8 are the address.
- Bits 7:0 are the data. For a write, the data comes from the host on MOSI. For a read, the data is returned to the host on MISO.

**SPI sampling and drive:**
- Inputs pass through `SYNC_STAGES` flops, then one extra flop for edge detection.
- MOSI is sampled on the detected SCK rising edge. MISO is updated on the detected SCK falling edge.
- `spi_miso_oe_o` = 1 while CSn is low (synchronized); 0 otherwise.
- `spi_miso_o` = 0 during bits 15:8.

**FSM** (states IDLE, HDR, DATA, DONE):
- IDLE → HDR on CSn falling edge. The bit counter is cleared.
- HDR shifts 8 bits.
  - On the 8th rising edge, latch `addr_o`.
  - If R/W = 0, start the read strobe. When it completes, load `read_data_i` into the TX shift register.
  - Go to DATA.
- DATA shifts 8 bits.
  - Read frame: TX bit 7 is presented on MISO at the falling edge after the 8th rising edge, then shifts.
  - Write frame: on the 16th rising edge, latch `write_data_o`, start the write strobe, and go to DONE.
  - Read frame: on the 16th rising edge, go to DONE.
- DONE ignores further SCK edges. It returns to IDLE on CSn rising edge.

**Strobes:**
- A single strobe counter drives `read_en_o`/`write_en_o` high for exactly `STROBE_CYCLES` cycles.
- `addr_o` and `write_data_o` hold their values until the next latch.

**Abort:**
- Trigger: CSn rises in HDR or DATA, i.e. fewer than 16 bits received.
- Response: pulse `abort_o`, go to IDLE, issue no write.
- A read strobe already in progress completes; its data is discarded.

**CSn glitch-free low with no SCK:** stays in HDR and issues no access.

## Timing
- **Reset:** all outputs 0, FSM IDLE, counters 0, synchronizers 0. Exception: the CSn synchronizer resets to 1.
- **Input latency:** `SYNC_STAGES`+1 = 3 clk cycles from pin to detected edge.
- **Read budget:**
  - Strobe starts 1 cycle after the 8th detected rising edge.
  - TX load happens the cycle after strobe end. With `STROBE_CYCLES`=3, load is at 8th edge + 5 cycles.
  - Total from pin to load: 3 + 5 = 8 cycles, which fits within a half SCK period at the /16 ratio.
- **Write:** `write_en_o` rises 1 cycle after the 16th detected rising edge.
- **Read-data sampling:** `read_data_i` is sampled on the last cycle of the read strobe. The downstream bank delivers valid data after 2 strobe cycles.
- **Back-to-back frames:** a new HDR phase cannot finish before the prior strobe ends, so no arbitration is needed.
- **Reset mid-frame or mid-strobe:** strobes drop immediately (asynchronous).

## Structure
- Package/include `spi_reg_pkg` holds:
  - FSM state encodings;
  - `FRAME_BITS`=16;
  - `RW_BIT`=15;
  - default `STROBE_CYCLES`.
- Sub-module `sync_2ff`: parameterized-depth, 1-bit synchronizer with asynchronous reset and a reset-value parameter. Instantiate it three times.

## Test plan
- **Write:** frame 0x853C → `addr_o`=0x05, `write_data_o`=0x3C, `write_en_o` high for 3 cycles, `abort_o`=0.
- **Read:** frame 0x0A00 with `read_data_i`=0xA5 → `read_en_o` high for 3 cycles with `addr_o`=0x0A, MISO bits 7:0 = 1,0,1,0,0,1,0,1.
- **Abort:** CSn rises after 12 bits of 0x9FFF → `abort_o` one-cycle pulse, no `write_en_o`, FSM IDLE.
- **Extra SCK:** 20 SCK edges with frame 0x8111 → exactly one write (addr 0x01, data 0x11); extra edges ignored.
- **Reset:** `rstn_n` asserted mid-DATA of a write frame → all outputs 0 immediately. The next full frame 0x8242 writes 0x42 to addr 0x02.
- **Back-to-back:** read 0x7F00 then write 0xFFAA at the /16 SCK ratio → both accesses issued in order; MISO returns `read_data_i`, and the write strobe carries addr 0x7F, data 0xAA.
